bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 4, number of masters sharing the tristate data bus; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum cycles one owner holds the bus; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N_MASTERS  per-master bus request, level-sensitive.
REQ-006 last  input  N_MASTERS  per-master final-beat flag, qualified by that master's grant bit.
REQ-007 grant  output  N_MASTERS  one-hot or all-zero, registered; bit i drives the enable of master i's ControlledBuffer.
REQ-008 grant_id  output  clog2(N_MASTERS)  index of the current owner; valid only while bus_busy=1.
REQ-009 bus_busy  output  1  high while any grant bit is high.
REQ-010 turnaround  output  1  high during the dead cycle between owners.
REQ-011 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and TURNAROUND.
REQ-013 IDLE: with req!=0 at edge t, the FSM SHALL enter GRANT with the winner's grant bit high from t+1 (1-cycle latency).
REQ-014 Winner selection SHALL be round-robin: first set req bit searching upward from rr_ptr, wrapping from N_MASTERS-1 to 0.
REQ-015 On each grant, rr_ptr SHALL load (winner+1) mod N_MASTERS.
REQ-016 GRANT: the owner's grant SHALL hold while req[owner]=1 and last[owner]=0; req/last of non-owners SHALL be ignored.
REQ-017 GRANT: last[owner]=1 or req[owner]=0 at an edge SHALL move the FSM to TURNAROUND, with grant all-zero on the next cycle.
REQ-018 TURNAROUND SHALL last exactly one cycle, with grant=0 and turnaround=1; at its exit edge the FSM SHALL arbitrate on current req, entering GRANT if req!=0 and IDLE otherwise.
REQ-019 grant SHALL never go directly from one nonzero value to a different nonzero value; at least one all-zero cycle separates owners.
REQ-020 A lone requester holding req high SHALL be re-granted after exactly one zero cycle.
REQ-021 The owner re-requesting with another master pending SHALL lose to the pending master.
REQ-022 grant, grant_id, bus_busy, turnaround and timeout_err SHALL all be flop outputs with no combinational path from req or last.

Reset
REQ-023 An edge with reset=1 SHALL force the state to IDLE and set grant=0, grant_id=0, bus_busy=0, turnaround=0, timeout_err=0, rr_ptr=0 and the hold counter to 0, overriding any transaction in progress.
REQ-024 The first edge after reset deasserts SHALL arbitrate from rr_ptr=0.

Configuration
REQ-025 Macro BUS_ARBITER_TIMEOUT_EN defined: a hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-026 With the macro defined, on the cycle the counter reaches TIMEOUT_CYCLES-1 without a release, the FSM SHALL force TURNAROUND and pulse timeout_err for that TURNAROUND cycle; rr_ptr still advances normally.
REQ-027 Macro undefined: no counter SHALL exist, timeout_err SHALL be tied 0, and ownership SHALL be unbounded.

Structure
REQ-028 Package bus_arbiter_pkg SHALL hold the state enum typedef (IDLE, GRANT, TURNAROUND) and the state-width constant.
REQ-029 Sub-module rr_picker SHALL be a combinational circuit (req, rr_ptr) -> one-hot winner plus index, instantiated once.

Verification
REQ-030 The bench SHALL cover: reset; req=4'b0100 held, last pulsed on the 3rd grant cycle -> grant=0100 for 3 cycles, 1 zero cycle, then grant=0100 again, grant_id=2.
REQ-031 The bench SHALL cover: req=4'b1111 held, each owner asserts last on its first grant cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-032 The bench SHALL cover: the owner drops req mid-transfer while req[3]=1 -> next cycle turnaround=1, following cycle grant=1000.
REQ-033 The bench SHALL cover: reset asserted during GRANT of master 1 -> next cycle grant=0, bus_busy=0, rr_ptr=0; with req=0011 after reset, master 0 wins.
REQ-034 The bench SHALL cover, with BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4: master 0 holds req with no last -> 4 grant cycles, then timeout_err=1 for one cycle, with no cycle where two grant bits are high.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the bus arbiter: FSM state encoding and
// the wrap-around index arithmetic used by round-robin search.
package bus_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_e;

  // (base + off) mod n, for base < n and off < n
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search. Returns the first set req bit
// at or above rr_ptr_i (wrapping), as a one-hot vector plus its index.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] rr_ptr_i,
  output logic [N-1:0]   win_o,
  output logic [IDW-1:0] win_idx_o,
  output logic           any_o
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(int'(rr_ptr_i), k, N)]) begin
        win_o     = '0;
        win_o[wrap_idx(int'(rr_ptr_i), k, N)] = 1'b1;
        win_idx_o = IDW'(wrap_idx(int'(rr_ptr_i), k, N));
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared tristate bus with a
// mandatory dead cycle between owners. All outputs are registered.
// Optional hold-time limit enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDW           = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] last,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDW-1:0]       grant_id,
  output logic                 bus_busy,
  output logic                 turnaround,
  output logic                 timeout_err
);

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]       gid_q, gid_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;
  logic                 ta_q, ta_d;
  logic                 terr_q, terr_d;
  logic                 hit_limit;
  logic                 release_req;

  logic [N_MASTERS-1:0] pick_win;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;

  rr_picker #(.N(N_MASTERS), .IDW(IDW)) u_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       grant_entry;

  // Hold counter: zero on entry to GRANT, +1 per GRANT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_entry)          cnt_d = '0;
    else if (state_q == GRANT) cnt_d = cnt_q + 8'd1;
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign grant_entry = (state_q != GRANT) && (state_d == GRANT);
  assign hit_limit   = (state_q == GRANT) && (cnt_q == CNT_LAST);
`else
  assign hit_limit   = 1'b0;
`endif

  // Owner finishes on last beat or by withdrawing its request.
  assign release_req = last[gid_q] | ~req[gid_q];

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    busy_d   = busy_q;
    ta_d     = 1'b0;
    terr_d   = 1'b0;
    unique case (state_q)
      IDLE, TURNAROUND: begin
        if (pick_any) begin
          state_d  = GRANT;
          grant_d  = pick_win;
          gid_d    = pick_idx;
          busy_d   = 1'b1;
          rr_ptr_d = IDW'(wrap_idx(int'(pick_idx), 1, N_MASTERS));
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (release_req || hit_limit) begin
          state_d = TURNAROUND;
          grant_d = '0;
          busy_d  = 1'b0;
          ta_d    = 1'b1;
          terr_d  = hit_limit && !release_req;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gid_q    <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      ta_q     <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      ta_q     <= ta_d;
      terr_q   <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = gid_q;
  assign bus_busy    = busy_q;
  assign turnaround  = ta_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_MASTERS=4, TIMEOUT_CYCLES=4).
// Outputs are checked 1 time unit after each rising edge.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, last, grant;
  logic [1:0] grant_id;
  logic       bus_busy, turnaround, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .last        (last),
    .grant       (grant),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .turnaround  (turnaround),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; last = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; last = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if ({grant, grant_id, bus_busy, turnaround, timeout_err} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs got g=%b id=%0d busy=%b ta=%b to=%b want all 0",
               grant, grant_id, bus_busy, turnaround, timeout_err);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd0) begin
      n_err++; $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr_q);
    end
    reset = 1'b0; req = '0;
    tick();
  endtask

  // Lone requester: 3 grant cycles, last on the 3rd, one dead cycle, re-grant.
  task automatic test_lone_requester();
    logic [3:0] exp_g [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    do_reset();
    req = 4'b0100; last = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (grant !== exp_g[c] || turnaround !== (exp_g[c] == 4'b0000)) begin
        n_err++;
        $display("FAIL lone_cycle%0d got g=%b ta=%b want g=%b", c, grant, turnaround, exp_g[c]);
      end
      last = (c == 2) ? 4'b0100 : 4'b0000;
    end
    n_cmp++;
    if (grant_id !== 2'd2 || bus_busy !== 1'b1) begin
      n_err++; $display("FAIL lone_id got id=%0d busy=%b want id=2 busy=1", grant_id, bus_busy);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || turnaround !== 1'b1 || bus_busy !== 1'b0) begin
      n_err++; $display("FAIL lone_drop got g=%b ta=%b busy=%b want g=0000 ta=1 busy=0",
                        grant, turnaround, bus_busy);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || turnaround !== 1'b0) begin
      n_err++; $display("FAIL lone_idle got g=%b ta=%b want g=0000 ta=0", grant, turnaround);
    end
  endtask

  // All four requesting, each finishing on its first beat.
  task automatic test_round_robin();
    logic [3:0] exp_g [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1111; last = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      tick();
      n_cmp++;
      if (grant !== exp_g[c] || bus_busy !== (exp_g[c] != 4'b0000)) begin
        n_err++;
        $display("FAIL rr_cycle%0d got g=%b busy=%b want g=%b", c, grant, bus_busy, exp_g[c]);
      end
    end
    req = '0; last = '0;
    tick(); tick();
  endtask

  // Owner withdraws mid-transfer while master 3 waits; non-owner req ignored.
  task automatic test_owner_drop();
    do_reset();
    req = 4'b0001; last = 4'b0000;
    tick();
    tick();
    req = 4'b1001;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL drop_hold got g=%b id=%0d want g=0001 id=0", grant, grant_id);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || turnaround !== 1'b1) begin
      n_err++; $display("FAIL drop_turn got g=%b ta=%b want g=0000 ta=1", grant, turnaround);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b1000 || grant_id !== 2'd3 || turnaround !== 1'b0) begin
      n_err++; $display("FAIL drop_next got g=%b id=%0d ta=%b want g=1000 id=3 ta=0",
                        grant, grant_id, turnaround);
    end
    req = '0;
    tick(); tick();
  endtask

  // Owner re-requests after finishing while another master is pending.
  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001; last = 4'b0000;
    tick();
    req = 4'b0011; last = 4'b0001;
    tick();
    last = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_err++; $display("FAIL b2b_pending got g=%b id=%0d want g=0010 id=1", grant, grant_id);
    end
    req = '0;
    tick(); tick();
  endtask

  // Reset in the middle of master 1's grant.
  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010; last = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || dut.rr_ptr_q !== 2'd2) begin
      n_err++; $display("FAIL rmid_grant got g=%b ptr=%0d want g=0010 ptr=2", grant, dut.rr_ptr_q);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || bus_busy !== 1'b0 || dut.rr_ptr_q !== 2'd0 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL rmid_reset got g=%b busy=%b ptr=%0d id=%0d want 0/0/0/0",
                        grant, bus_busy, dut.rr_ptr_q, grant_id);
    end
    reset = 1'b0; req = 4'b0011;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL rmid_after got g=%b id=%0d want g=0001 id=0", grant, grant_id);
    end
    req = '0;
    tick(); tick();
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  // Master 0 holds without last: 4 grant cycles then forced release.
  task automatic test_timeout();
    do_reset();
    req = 4'b0001; last = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001 || timeout_err !== 1'b0 || $countones(grant) > 1) begin
        n_err++; $display("FAIL to_hold%0d got g=%b to=%b want g=0001 to=0", c, grant, timeout_err);
      end
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || timeout_err !== 1'b1 || turnaround !== 1'b1) begin
      n_err++; $display("FAIL to_pulse got g=%b to=%b ta=%b want g=0000 to=1 ta=1",
                        grant, timeout_err, turnaround);
    end
    n_cmp++;
    if (dut.rr_ptr_q !== 2'd1) begin
      n_err++; $display("FAIL to_ptr got %0d want 1", dut.rr_ptr_q);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL to_regrant got g=%b to=%b want g=0001 to=0", grant, timeout_err);
    end
    req = '0;
    tick(); tick();
  endtask
`else
  // Without the limit, ownership is unbounded and timeout_err stays low.
  task automatic test_timeout();
    do_reset();
    req = 4'b0001; last = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001 || timeout_err !== 1'b0) begin
        n_err++; $display("FAIL nolimit_hold%0d got g=%b to=%b want g=0001 to=0",
                          c, grant, timeout_err);
      end
    end
    req = '0;
    tick(); tick();
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; last = '0;
    test_reset();
    test_lone_requester();
    test_round_robin();
    test_owner_drop();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
